// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Holds the FSM state type, default widths and the skid depth.
package fifo_rd_pkg;

    localparam int DSIZE_DEF  = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int SUM_W_DEF  = 16;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream stream for the burst reader.
// Stream handshake: a word moves on any rising edge where m_valid && m_ready; m_data is held while m_valid && !m_ready.
interface fifo_burst_reader_if #(parameter int DSIZE = 8);

    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_data, m_valid
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_data, m_valid
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered skid buffer between the FIFO pop path and the downstream stream.
// slot0 is always the oldest word and drives m_data directly.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    output logic             space,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       cnt
);

    logic [DSIZE-1:0] slot0;
    logic [DSIZE-1:0] slot1;
    logic             pop;

    assign pop     = m_valid && m_ready;
    assign m_valid = (cnt != 2'd0);
    assign m_data  = slot0;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign space   = (cnt < 2'(SKID_DEPTH)) || pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop) begin
                if (push && cnt == 2'd1) slot0 <= push_data;
                else                     slot0 <= slot1;
                if (push && cnt == 2'd2) slot1 <= push_data;
            end else if (push) begin
                if (cnt == 2'd0) slot0 <= push_data;
                else             slot1 <= push_data;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-domain burst consumer: pops len words from the FIFO into a skid buffer,
// forwards them downstream and reports count, checksum and a done pulse.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    fifo_burst_reader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    rd_count,
    output logic [SUM_W-1:0]    sum,
    output rd_state_t           dbg_state
);

    rd_state_t        state;
    rd_state_t        state_next;
    logic [LEN_W-1:0] remaining;
    logic             space;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic [1:0]       buf_cnt;
    logic             rinc;
    logic             xfer;

    assign xfer        = m_valid && bus.m_ready;
    assign bus.rinc    = rinc;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_data;
    assign dbg_state   = state;

    fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
        .clk       (rclk),
        .rst       (rrst),
        .push      (rinc),
        .push_data (bus.rdata),
        .space     (space),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (bus.m_ready),
        .cnt       (buf_cnt)
    );

    always_ff @(posedge rclk) begin
        if (rrst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len != '0) ? READ : DONE;
            READ:    if (rinc && remaining == LEN_W'(1)) state_next = DRAIN;
            // Leave once the last buffered word is accepted downstream.
            DRAIN:   if (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && xfer)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == READ) || (state == DRAIN);
        done = (state == DONE);
        rinc = (state == READ) && !rrst && !bus.rempty && (remaining != '0) && space;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            remaining <= '0;
            rd_count  <= '0;
            sum       <= '0;
        end else if (state == IDLE && start) begin
            remaining <= len;
            rd_count  <= '0;
            sum       <= '0;
        end else begin
            if (rinc) remaining <= remaining - LEN_W'(1);
            if (xfer) begin
                rd_count <= rd_count + LEN_W'(1);
                sum      <= sum + SUM_W'(m_data);
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: a queue-based FIFO and word model
// predicts delivered data, counts, checksums and done pulses.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy, done;
    logic [7:0] rd_count;
    logic [15:0] sum;
    rd_state_t  dbg_state;

    fifo_burst_reader_if #(.DSIZE(8)) bus ();

    fifo_burst_reader #(.DSIZE(8), .LEN_W(8), .SUM_W(16)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .start     (start),
        .len       (len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .rd_count  (rd_count),
        .sum       (sum),
        .dbg_state (dbg_state)
    );

    always #5 rclk = ~rclk;

    // Behavioural FIFO: words written by the writer process, popped on rinc.
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         wr_rate = 100;
    logic [7:0] pend_q [$];
    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];

    assign bus.rempty = (wr_ptr == rd_ptr);
    assign bus.rdata  = mem[rd_ptr[7:0]];

    always @(posedge rclk) if (bus.rinc) rd_ptr <= rd_ptr + 1;

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge rclk); #1;
            if (pend_q.size() != 0 && $urandom_range(1, 100) <= wr_rate) begin
                mem[wr_ptr[7:0]] = pend_q.pop_front();
                wr_ptr = wr_ptr + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    int         rinc_cnt = 0, done_cnt = 0, busy_cnt = 0, xfer_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge rclk) begin
        if (rrst) begin
            check("rinc_in_reset", bus.rinc, 0);
            prev_stall = 1'b0;
        end else begin
            if (bus.rinc) begin
                rinc_cnt++;
                check("rinc_while_empty", bus.rempty, 0);
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (prev_stall) check("m_data_hold", bus.m_data, prev_data);
            if (bus.m_valid && bus.m_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) check("unexpected_word", bus.m_data, 32'hffff_ffff);
                else check("m_data", bus.m_data, exp_q.pop_front());
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic enqueue(input logic [7:0] w);
        pend_q.push_back(w);
        model_q.push_back(w);
    endtask

    task automatic wait_written();
        for (int i = 0; i < 500 && pend_q.size() != 0; i++) begin
            @(posedge rclk); #1;
        end
        check("preload_done", pend_q.size(), 0);
    endtask

    task automatic pulse_start(input int blen);
        @(posedge rclk); #1;
        start = 1'b1;
        len   = 8'(blen);
        @(posedge rclk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready low for hold cycles then 1.
    task automatic run_burst(input int blen, input int mode, input int hold, input int extra_at);
        int   r0, d0, b0, cyc, done_cyc, exp_sum;
        logic got_done;
        logic [7:0] first_w;
        exp_sum = 0;
        first_w = 8'h00;
        for (int i = 0; i < blen; i++) begin
            logic [7:0] w;
            w = model_q.pop_front();
            if (i == 0) first_w = w;
            exp_q.push_back(w);
            exp_sum += int'(w);
        end
        r0 = rinc_cnt; d0 = done_cnt; b0 = busy_cnt;
        bus.m_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        pulse_start(blen);
        cyc = 0; done_cyc = -1; got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(negedge rclk);
            if (done) begin got_done = 1'b1; done_cyc = cyc; end
            @(posedge rclk); #1;
            cyc++;
            start = (cyc == extra_at);
            len   = (cyc == extra_at) ? 8'd5 : 8'(blen);
            if (mode == 2 && cyc == hold) begin
                check("stall_rinc_count", rinc_cnt - r0, 2);
                check("stall_m_data", bus.m_data, first_w);
            end
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = (cyc >= hold);
            endcase
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        if (blen == 0) check("done_latency", done_cyc, 0);
        @(posedge rclk); #1;
        check("rinc_total", rinc_cnt - r0, blen);
        check("done_once", done_cnt - d0, 1);
        check("busy_cycles_nonzero", (busy_cnt - b0) != 0, blen != 0);
        check("rd_count", rd_count, blen);
        check("sum", sum, exp_sum % 65536);
        check("sb_drained", exp_q.size(), 0);
        check("fifo_left", (wr_ptr - rd_ptr) + pend_q.size(), model_q.size());
        check("state_idle", dbg_state, IDLE);
    endtask

    int         x0, r0, popped, delivered, r1;
    logic [7:0] burst_w [$];

    initial begin
        repeat (3) @(posedge rclk);
        #1 rrst = 1'b0;
        @(negedge rclk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_sum", sum, 0);
        check("rst_rinc", bus.rinc, 0);
        check("rst_state", dbg_state, IDLE);

        // Ten ascending words at full throughput.
        for (int i = 1; i <= 10; i++) enqueue(8'(i));
        wait_written();
        run_burst(10, 0, 0, -1);
        check("t1_sum_const", sum, 16'h0037);

        // Downstream stalled for five cycles.
        for (int i = 1; i <= 4; i++) enqueue(8'(i));
        wait_written();
        run_burst(4, 2, 5, -1);

        // Empty FIFO, words trickle in.
        wr_rate = 20;
        enqueue(8'hAA); enqueue(8'hBB); enqueue(8'hCC);
        run_burst(3, 1, 0, -1);
        check("t3_sum_const", sum, 16'h0231);

        // Zero-length burst.
        run_burst(0, 0, 0, -1);

        // Reset in the middle of a burst.
        wr_rate = 100;
        for (int i = 0; i < 8; i++) enqueue(8'($urandom_range(0, 255)));
        wait_written();
        burst_w.delete();
        for (int i = 0; i < 8; i++) begin
            burst_w.push_back(model_q[0]);
            exp_q.push_back(model_q.pop_front());
        end
        x0 = xfer_cnt; r0 = rinc_cnt;
        bus.m_ready = 1'b1;
        pulse_start(8);
        for (int i = 0; i < 100 && (xfer_cnt - x0) < 3; i++) begin
            @(posedge rclk); #1;
        end
        check("reset_reached_3", (xfer_cnt - x0) >= 3, 1);
        rrst = 1'b1;
        @(posedge rclk); #1;
        rrst = 1'b0;
        delivered = xfer_cnt - x0;
        popped = rinc_cnt - r0;
        exp_q.delete();
        @(negedge rclk);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_count", rd_count, 0);
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_popped", popped >= delivered && popped <= delivered + 2, 1);
        check("mid_rst_fifo_left", wr_ptr - rd_ptr, 8 - popped);
        for (int i = 7; i >= popped; i--) model_q.push_front(burst_w[i]);
        r1 = rinc_cnt;
        repeat (5) @(posedge rclk);
        #1;
        check("mid_rst_no_rinc", rinc_cnt - r1, 0);
        run_burst(8 - popped, 1, 0, -1);

        // Start while busy is ignored.
        for (int i = 0; i < 7; i++) enqueue(8'($urandom_range(0, 255)));
        wait_written();
        run_burst(2, 1, 0, 1);
        run_burst(5, 1, 0, -1);

        // Random bursts with random gaps and backpressure.
        for (int t = 0; t < 6; t++) begin
            int blen;
            blen = $urandom_range(1, 12);
            wr_rate = $urandom_range(20, 100);
            for (int i = 0; i < blen + int'($urandom_range(0, 3)); i++)
                enqueue(8'($urandom_range(0, 255)));
            run_burst(blen, int'($urandom_range(0, 1)), 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side consumer for the dual-clock FIFO. It lives in the read clock domain and issues rinc pops against rempty/rdata on command. Popped words are forwarded to a downstream valid/ready stream through a 2-entry skid buffer. Each burst reports a completion pulse, a word count and a running checksum, replacing ad-hoc rinc toggling in benches and subsystems.

Parameters:
DSIZE, 8, FIFO data width (matches FIFO DSIZE)
LEN_W, 8, width of burst length / count
SUM_W, 16, checksum width

Ports:
rclk  in  1  read-domain clock; all logic on rising edge
rrst  in  1  reset, synchronous, active-high
start  in  1  1-cycle pulse; launches a burst of len words
len  in  LEN_W  burst length, sampled when start is accepted
rempty  in  1  FIFO empty flag (read domain)
rdata  in  DSIZE  FIFO read data; valid in the same cycle whenever rempty=0
rinc  out  1  FIFO pop; combinational from registered state and inputs
m_data  out  DSIZE  downstream data (head of skid buffer)
m_valid  out  1  downstream valid
m_ready  in  1  downstream ready
busy  out  1  high from the cycle after start acceptance until done
done  out  1  1-cycle pulse at burst completion
rd_count  out  LEN_W  words delivered downstream in the current/last burst
sum  out  SUM_W  sum of delivered words mod 2^SUM_W, zero-extended

Behaviour:
- Reset (rrst=1 at an rclk edge): state=IDLE; remaining, rd_count, sum =0; skid buffer emptied; busy, done, m_valid =0; rinc=0 while rrst=1. FIFO contents are not touched. Reset mid-burst abandons the burst; any words already popped into the skid buffer are discarded.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 -> remaining<=len, rd_count<=0, sum<=0.
  - len!=0 -> READ.
  - len=0 -> DONE; no rinc is issued.
- start is ignored in every state except IDLE.
- READ: rinc = !rempty && remaining!=0 && space.
  - space = (buf_cnt<2) || (m_valid && m_ready).
  - On rinc, rdata is written into the buffer at the same edge and remaining decrements.
  - When remaining reaches 0, at the edge of the last pop -> DRAIN.
- DRAIN: no rinc. Transition to DONE at the edge where buf_cnt becomes 0.
- DONE: done=1 for exactly one cycle; busy=0; next state IDLE. start is ignored in DONE and is accepted again from IDLE on the following cycle.
- busy=1 in READ and DRAIN only.
- Skid buffer:
  - 2 entries, FIFO order.
  - m_valid = buf_cnt!=0; m_data = oldest entry.
  - Simultaneous push and pop with buf_cnt=2 is legal; count stays 2 and order is preserved.
  - m_data is stable while m_valid && !m_ready.
- Each downstream transfer (m_valid && m_ready): rd_count+1 and sum += m_data (wraps mod 2^SUM_W). Both hold their value after done until the next accepted start.
- Latency: start accepted at edge 0 -> READ from edge 0. The first rinc is possible in cycle 1 (after edge 0), so m_valid is possible from edge 1 onward. With m_ready=1 and no empties, throughput is 1 word/cycle.
- rempty=1 during READ stalls with rinc=0; the burst resumes when data arrives. There is no timeout.
- rinc must never be asserted while rempty=1 or while rrst=1.

Decomposition:
- Package fifo_rd_pkg:
  - FSM state enum (IDLE, READ, DRAIN, DONE)
  - default DSIZE/LEN_W/SUM_W constants
  - skid depth constant (2)
- Sub-module fifo_rd_skid: 2-entry valid/ready skid buffer with push, push_data, space, m_* outputs and a synchronous active-high reset. The top holds the FSM, counters and checksum.

Test Plan:
- Preload FIFO with 10 words 0x01..0x0A, m_ready=1, start len=10 -> exactly 10 rinc pulses and m_data 0x01..0x0A in order; done pulses once; rd_count=10, sum=0x0037.
- Preload 4 words, start len=4, m_ready=0 for 5 cycles then 1 -> only 2 rinc pulses while stalled and m_data holds 0x01; after release, 4 words delivered in order; done once; rd_count=4.
- FIFO empty, start len=3, then write 0xAA, 0xBB, 0xCC at the write side with gaps -> rinc=0 whenever rempty=1; outputs AA, BB, CC; done; sum=0x0231.
- start len=0 -> no rinc; done one cycle after start; busy never high; rd_count=0, sum=0.
- Assert rrst=1 for 1 cycle mid-burst (len=8, after 3 words delivered) -> next cycle m_valid=0, busy=0, rd_count=0; rinc stays 0 until a new start; the remaining FIFO words are still present.
- Pulse start again while busy (len=5 during a len=2 burst) -> ignored: exactly 2 words are read and done fires once.
